// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: widths, NOP encoding, reset PC and RV32 opcodes.
package instruction_fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RV32I major opcodes, shared with the decoder
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // One queued fetch result
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read channel: one-beat request, one-cycle response pulse.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  // Fetch unit side
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // Memory side
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: circular FIFO of fetched {instr, pc}, sync flush, push+pop same cycle.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head_ptr, tail_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[head_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + AW'(1);
      if (do_pop)  head_ptr <= head_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory reads into a small queue feeding decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter  logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter  int              QUEUE_DEPTH = 4,
  localparam int              CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master mem,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                available,
  output logic                decode_pulse,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic [CW-1:0]       queue_count
);

  logic [XLEN-1:0] fetch_pc, req_pc, req_addr;
  logic            req_valid, outstanding, discard;
  logic            handshake, resp_accept, push, pop, raise, busy_next, q_empty;
  logic [CW:0]     count_next;
  fetch_entry_t    head;

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = req_addr;

  assign handshake   = req_valid & mem.mem_req_ready;
  assign resp_accept = mem.mem_resp_valid & outstanding;
  assign push        = resp_accept & ~discard & ~redirect_valid;
  assign pop         = available & ~q_empty & ~redirect_valid;
  assign count_next  = {1'b0, queue_count} + (CW+1)'(push) - (CW+1)'(pop);
  // Raise only when nothing is in flight after this edge and a queue slot is free for the reply
  assign raise       = ~req_valid & ~handshake & (~outstanding | mem.mem_resp_valid)
                     & (count_next < (CW+1)'(QUEUE_DEPTH));
  // A read still in flight across a redirect must have its reply thrown away
  assign busy_next   = (outstanding & ~mem.mem_resp_valid) | handshake;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ('{instr: mem.mem_resp_data, pc: req_pc}),
    .pop       (pop),
    .head      (head),
    .empty     (q_empty),
    .count     (queue_count)
  );

  // Request/response tracking and decode dispatch; redirect overrides everything
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      req_valid    <= 1'b0;
      req_addr     <= '0;
      outstanding  <= 1'b0;
      discard      <= 1'b0;
      decode_pulse <= 1'b0;
      instr        <= NOP_INSTR;
      instr_pc     <= '0;
    end else if (redirect_valid) begin
      fetch_pc     <= word_align(redirect_pc);
      req_valid    <= 1'b0;
      outstanding  <= busy_next;
      discard      <= busy_next;
      if (handshake) req_pc <= req_addr;
      decode_pulse <= 1'b0;
    end else begin
      decode_pulse <= pop;
      if (pop) begin
        instr    <= head.instr;
        instr_pc <= head.pc;
      end
      if (handshake) begin
        req_valid   <= 1'b0;
        outstanding <= 1'b1;
        req_pc      <= req_addr;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (resp_accept) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (raise) begin
        req_valid <= 1'b1;
        req_addr  <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-selectable memory responder.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        available;
  logic        decode_pulse;
  logic [31:0] instr, instr_pc;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch_if mif();

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .mem            (mif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .available      (available),
    .decode_pulse   (decode_pulse),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .queue_count    (queue_count)
  );

  always #5 clock = ~clock;

  // Memory model: reply data is ~address, after 1 or 2 cycles
  logic        lat2 = 1'b0;
  logic        hs1 = 1'b0, hs2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;
  logic        ready;
  always @(posedge clock) begin
    hs1 <= mif.mem_req_valid & mif.mem_req_ready;
    a1  <= mif.mem_req_addr;
    hs2 <= hs1;
    a2  <= a1;
  end
  assign mif.mem_req_ready  = ready;
  assign mif.mem_resp_valid = lat2 ? hs2 : hs1;
  assign mif.mem_resp_data  = ~(lat2 ? a2 : a1);

  // Logs of accepted request addresses and dispatched instructions
  logic [31:0] req_log[$];
  logic [31:0] pulse_pc[$];
  logic [31:0] pulse_ins[$];
  always @(posedge clock) begin
    if (!reset && mif.mem_req_valid && mif.mem_req_ready) req_log.push_back(mif.mem_req_addr);
    if (decode_pulse) begin
      pulse_pc.push_back(instr_pc);
      pulse_ins.push_back(instr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int r0, p0;

    // Reset values
    reset = 1'b1; ready = 1'b0; available = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(3);
    chk("rst_req_valid", {31'b0, mif.mem_req_valid}, 32'd0);
    chk("rst_req_addr", mif.mem_req_addr, 32'd0);
    chk("rst_pulse", {31'b0, decode_pulse}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_count", {29'b0, queue_count}, 32'd0);

    // Streaming fetch with immediate dispatch
    r0 = req_log.size(); p0 = pulse_pc.size();
    reset = 1'b0; ready = 1'b1; available = 1'b1;
    step(15);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s_req%0d", i), req_log[r0+i], 32'(4*i));
      chk($sformatf("s_pc%0d", i), pulse_pc[p0+i], 32'(4*i));
      chk($sformatf("s_ins%0d", i), pulse_ins[p0+i], ~32'(4*i));
    end

    // Decode stalled: queue fills, fetch stops, then drains back-to-back
    reset = 1'b1; step(2);
    r0 = req_log.size();
    reset = 1'b0; available = 1'b0;
    step(20);
    chk("full_count", {29'b0, queue_count}, 32'd4);
    chk("full_req_valid", {31'b0, mif.mem_req_valid}, 32'd0);
    chk("full_nreq", 32'(req_log.size() - r0), 32'd4);
    available = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain_pulse%0d", i), {31'b0, decode_pulse}, 32'd1);
      chk($sformatf("drain_pc%0d", i), instr_pc, 32'(4*i));
      if (i == 0) begin
        chk("drain_ins0", instr, 32'hFFFF_FFFF);
        chk("resume_valid", {31'b0, mif.mem_req_valid}, 32'd1);
        chk("resume_addr", mif.mem_req_addr, 32'h10);
      end
    end

    // Memory back-pressure: request held stable
    reset = 1'b1; ready = 1'b0; step(2);
    r0 = req_log.size();
    reset = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid%0d", i), {31'b0, mif.mem_req_valid}, 32'd1);
      chk($sformatf("hold_addr%0d", i), mif.mem_req_addr, 32'd0);
      if (i < 4) step();
    end
    ready = 1'b1;
    step();
    chk("hold_nreq", 32'(req_log.size() - r0), 32'd1);
    chk("hold_req0", req_log[r0], 32'd0);
    chk("hold_valid_after", {31'b0, mif.mem_req_valid}, 32'd0);

    // Redirect while a read is outstanding with two entries queued
    reset = 1'b1; available = 1'b0; lat2 = 1'b1; step(2);
    r0 = req_log.size(); p0 = pulse_pc.size();
    reset = 1'b0;
    for (int i = 0; i < 40 && (req_log.size() - r0) < 3; i++) step();
    chk("redir_nreq", 32'(req_log.size() - r0), 32'd3);
    chk("redir_count_pre", {29'b0, queue_count}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0; available = 1'b1;
    chk("redir_count", {29'b0, queue_count}, 32'd0);
    chk("redir_req_valid", {31'b0, mif.mem_req_valid}, 32'd0);
    chk("redir_pulse", {31'b0, decode_pulse}, 32'd0);
    step(12);
    chk("redir_req3", req_log[r0+3], 32'h100);
    chk("redir_pc0", pulse_pc[p0], 32'h100);
    chk("redir_ins0", pulse_ins[p0], ~32'h100);

    // Redirect to top of address space wraps
    reset = 1'b1; lat2 = 1'b0; step(2);
    r0 = req_log.size(); p0 = pulse_pc.size();
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step(12);
    chk("wrap_req0", req_log[r0], 32'hFFFF_FFFC);
    chk("wrap_req1", req_log[r0+1], 32'h0);
    chk("wrap_pc0", pulse_pc[p0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pulse_pc[p0+1], 32'h0);

    // Reset mid-transaction; late reply must be ignored
    reset = 1'b1; lat2 = 1'b1; step(2);
    r0 = req_log.size(); p0 = pulse_pc.size();
    reset = 1'b0;
    for (int i = 0; i < 20 && (req_log.size() - r0) < 1; i++) step();
    chk("late_nreq", 32'(req_log.size() - r0), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("late_count0", {29'b0, queue_count}, 32'd0);
    chk("late_req_valid", {31'b0, mif.mem_req_valid}, 32'd1);
    chk("late_req_addr", mif.mem_req_addr, 32'd0);
    step();
    chk("late_count1", {29'b0, queue_count}, 32'd0);
    step(8);
    chk("late_req1", req_log[r0+1], 32'd0);
    chk("late_pc0", pulse_pc[p0], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 mem_req_valid  out  1  instruction read request.
REQ-007 mem_req_addr  out  32  word-aligned read address.
REQ-008 mem_req_ready  in  1  memory accepts request this cycle.
REQ-009 mem_resp_valid  in  1  read data valid, 1-cycle pulse.
REQ-010 mem_resp_data  in  32  instruction word.
REQ-011 redirect_valid  in  1  branch/jump/flush restart.
REQ-012 redirect_pc  in  32  restart address.
REQ-013 available  in  1  decode/ROB can take an instruction this cycle.
REQ-014 decode_pulse  out  1  one-cycle strobe: instr/instr_pc valid for decode.
REQ-015 instr  out  32  instruction word to decode.
REQ-016 instr_pc  out  32  address of instr.
REQ-017 queue_count  out  clog2(QUEUE_DEPTH)+1  occupied queue entries.

Function
REQ-018 Fetch PC SHALL increment by 4 per accepted request, modulo 2^32.
REQ-019 At most one memory request SHALL be outstanding; a new request is raised only when none is outstanding and queue_count + 1 <= QUEUE_DEPTH (slot reserved).
REQ-020 mem_req_valid and mem_req_addr SHALL hold stable until mem_req_ready, except withdrawal on redirect.
REQ-021 On mem_req_valid & mem_req_ready: outstanding set, request PC latched, fetch PC += 4; earliest next request is the cycle after the response.
REQ-022 On mem_resp_valid with outstanding set and discard clear: {mem_resp_data, request PC} pushed to queue tail; outstanding cleared.
REQ-023 mem_resp_valid with no outstanding request SHALL be ignored.
REQ-024 When queue non-empty and available=1: decode_pulse=1 for exactly one cycle, instr/instr_pc registered from head on the same edge, head popped; at most one dispatch per cycle.
REQ-025 instr and instr_pc SHALL hold their last dispatched values while decode_pulse=0.
REQ-026 Push and pop in the same cycle SHALL leave queue_count unchanged; order strictly FIFO.
REQ-027 Queue empty: decode_pulse=0 regardless of available. Queue full: no new request.
REQ-028 redirect_valid has highest priority: queue flushed (count 0), fetch PC <= {redirect_pc[31:2],2'b00}, mem_req_valid deasserted that cycle, no decode_pulse that cycle.
REQ-029 Redirect while outstanding SHALL set discard; the next response is dropped and clears both outstanding and discard.
REQ-030 Redirect coinciding with mem_resp_valid SHALL drop that response.
REQ-031 Redirect coinciding with a request handshake SHALL treat the request as outstanding-and-discarded.
REQ-032 First request after redirect SHALL issue no earlier than the following cycle, at the new PC.

Reset
REQ-033 On reset: fetch PC=RESET_PC, queue empty, outstanding=0, discard=0, mem_req_valid=0, mem_req_addr=0, decode_pulse=0, instr=32'h00000013 (NOP), instr_pc=0, queue_count=0.
REQ-034 Reset mid-transaction SHALL abandon any outstanding request; a late response is ignored per REQ-023.

Structure
REQ-035 Shared package SHALL hold XLEN=32, NOP_INSTR=32'h00000013, the default RESET_PC and the RISC-V opcode constants shared with the decoder.
REQ-036 Queue SHALL be a sub-module fetch_queue: circular buffer, head/tail pointers with wrap, count, synchronous flush, push/pop same cycle.

Verification
REQ-037 Reset, mem_req_ready=1, 1-cycle response, available=1 -> requests 0x0,0x4,0x8; decode_pulse with instr_pc 0x0,0x4,0x8 in order, data matches.
REQ-038 available=0, responses keep coming -> queue_count reaches 4, mem_req_valid stays 0; available=1 -> four pulses back-to-back, then fetch resumes at 0x10.
REQ-039 mem_req_ready=0 for 5 cycles -> mem_req_valid=1, mem_req_addr=0x0 constant throughout; handshake on cycle 6.
REQ-040 Redirect to 0x103 while request 0x8 outstanding, 2 entries queued -> queue_count=0, response for 0x8 dropped, next request 0x100, next decode_pulse instr_pc=0x100.
REQ-041 Redirect_pc 0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000.
REQ-042 Reset asserted while outstanding, response arrives cycle after reset -> response ignored, queue_count=0, first request at RESET_PC.
